id_exe_pipe_reg: RTL
====================

Name: id_exe_pipe_reg

Overview:
- Pipeline register between the decode (ID) stage and the execute (EXE) stage of the ARM-subset 5-stage core.
- Latches the decoded instruction bundle (operands, EXE_CMD, control bits) for the ALU and Val2 generator.
- Owns the architectural status register (NZCV): feeds Status to the ALU and captures the ALU Flags for S-suffixed instructions.
- Inserts bubbles on hazard stall or branch flush, and holds completely during a memory freeze.

Parameters:
DATA_W, 32, width of PC and register operands
REG_ADDR_W, 4, register index width

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
mem_freeze  in  1  memory-wait freeze; hold all state
flush  in  1  branch taken in EXE; next entry becomes bubble
hazard  in  1  data hazard detected in ID; next entry becomes bubble
id_valid  in  1  ID bundle is a real instruction
id_pc  in  DATA_W  PC+4 of the ID instruction
id_val_rn  in  DATA_W  Rn read data
id_val_rm  in  DATA_W  Rm read data
id_imm  in  1  I bit
id_shift_operand  in  12  shifter operand field
id_signed_imm_24  in  24  branch offset
id_dest  in  REG_ADDR_W  destination register
id_src1, id_src2  in  REG_ADDR_W  source indices (forwarding)
id_exe_cmd  in  4  ALU command
id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s  in  1 each  control bits
alu_flags  in  4  NZCV from ALU (N=bit3 … V=bit0)
exe_* (one per id_* field, plus exe_valid)  out  same widths  registered bundle
status  out  4  current NZCV to ALU and condition check

Behaviour:
- Reset (async, immediate): every exe_* output is 0, exe_valid=0, status=4'b0000.
- Each rising edge applies exactly one action, in priority order:
  1. mem_freeze=1: hold all bundle fields and status unchanged. flush and hazard are ignored; the branch in EXE is still held and re-asserts flush after the freeze releases.
  2. flush=1: load a bubble.
  3. hazard=1: load a bubble.
  4. Otherwise: load the id_* bundle, with exe_valid=id_valid.
- Bubble definition:
  - exe_valid=0; exe_wb_en=exe_mem_r_en=exe_mem_w_en=exe_b=exe_s=0; exe_exe_cmd=4'b0000.
  - Data fields (pc, val_rn/rm, shift_operand, imm24, dest, src) are loaded from ID anyway and are don't-care. Verify only control bits.
- Control bits are also forced to 0 whenever id_valid=0, regardless of the id_* values.
- Latency: an ID bundle appears on exe_* one cycle after its capture edge.
- Status register:
  - Updates on a rising edge when mem_freeze=0 && exe_valid=1 && exe_s=1: status <= alu_flags. This captures the flags of the instruction currently leaving EXE.
  - Otherwise status holds.
  - A flush in the same cycle does not block the update: the S-instruction in EXE is architecturally complete.
- Simultaneous events: flush+hazard give one bubble. Under freeze, even if flush+hazard are asserted, nothing changes.
- Reset asserted mid-freeze or mid-stream clears everything. First load occurs on the first edge after rst deasserts.

Decomposition:
- Shared package core_pkg:
  - EXE_CMD constants (MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000, NOP=0000).
  - NZCV bit-index constants (N=3, Z=2, C=1, V=0).
  - Packed id_exe_bundle_t typedef.
- One sub-module, status_reg: 4-bit register with enable and async reset. Instantiated here so the MEM-stage freeze logic can reuse it.

Test Plan:
- Reset: assert rst with id_valid=1 and id_wb_en=1 → all exe_* =0, status=0 immediately, before any clock edge.
- Normal flow: id_val_rn=32'h0000_0005, id_exe_cmd=0010, id_wb_en=1, id_dest=3 → next cycle exe_val_rn=5, exe_exe_cmd=0010, exe_wb_en=1, exe_dest=3, exe_valid=1.
- Hazard bubble then resume: hazard=1 for 1 cycle with an ADD in ID → exe_valid=0, exe_wb_en=0, exe_exe_cmd=0. Next cycle with hazard=0, the ADD appears.
- Freeze precedence: mem_freeze=1 for 3 cycles with flush=1 and a new ID bundle → exe_* and status unchanged throughout. After release with flush=1 → bubble.
- Status capture: SUB with S=1 in EXE, alu_flags=4'b0110 → status=0110 next cycle. Same instruction with S=0, or exe_valid=0, or mem_freeze=1 → status stays at its previous value.
- Flush with S in EXE: exe_s=1, flush=1, alu_flags=4'b1000 → status=1000 and exe_valid=0 on the same edge.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_pkg                                                         |
// | Shared types and constants for the ARM-subset 5-stage core.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package core_pkg;

    localparam int CORE_DATA_W     = 32;
    localparam int CORE_REG_ADDR_W = 4;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic                       valid;
        logic [CORE_DATA_W-1:0]     pc;
        logic [CORE_DATA_W-1:0]     val_rn;
        logic [CORE_DATA_W-1:0]     val_rm;
        logic                       imm;
        logic [11:0]                shift_operand;
        logic [23:0]                signed_imm_24;
        logic [CORE_REG_ADDR_W-1:0] dest;
        logic [CORE_REG_ADDR_W-1:0] src1;
        logic [CORE_REG_ADDR_W-1:0] src2;
        logic [3:0]                 exe_cmd;
        logic                       wb_en;
        logic                       mem_r_en;
        logic                       mem_w_en;
        logic                       b;
        logic                       s;
    } id_exe_bundle_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/status_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | status_reg                                                       |
// | Enabled flag register with asynchronous active-high reset.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module status_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] flags_d;
    logic [WIDTH-1:0] flags_q;

    always_comb begin
        flags_d = flags_q;
        if (en) begin
            flags_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign q = flags_q;

endmodule : status_reg
`default_nettype wire

// File: rtl/id_exe_pipe_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_exe_pipe_reg                                                  |
// | ID->EXE pipeline register with bubble insertion and NZCV owner.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module id_exe_pipe_reg
    import core_pkg::*;
#(
    parameter int DATA_W     = CORE_DATA_W,
    parameter int REG_ADDR_W = CORE_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_freeze,
    input  logic                  flush,
    input  logic                  hazard,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic                  id_imm,
    input  logic [11:0]           id_shift_operand,
    input  logic [23:0]           id_signed_imm_24,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [3:0]            id_exe_cmd,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic [3:0]            alu_flags,
    output logic                  exe_valid,
    output logic [DATA_W-1:0]     exe_pc,
    output logic [DATA_W-1:0]     exe_val_rn,
    output logic [DATA_W-1:0]     exe_val_rm,
    output logic                  exe_imm,
    output logic [11:0]           exe_shift_operand,
    output logic [23:0]           exe_signed_imm_24,
    output logic [REG_ADDR_W-1:0] exe_dest,
    output logic [REG_ADDR_W-1:0] exe_src1,
    output logic [REG_ADDR_W-1:0] exe_src2,
    output logic [3:0]            exe_exe_cmd,
    output logic                  exe_wb_en,
    output logic                  exe_mem_r_en,
    output logic                  exe_mem_w_en,
    output logic                  exe_b,
    output logic                  exe_s,
    output logic [3:0]            status
);

    id_exe_bundle_t bundle_d;
    id_exe_bundle_t bundle_q;
    logic           bubble;
    logic           status_en;

    // Data fields always follow ID; only control is squashed on a bubble.
    always_comb begin
        bundle_d = bundle_q;
        bubble   = flush | hazard | ~id_valid;
        if (!mem_freeze) begin
            bundle_d.valid         = id_valid & ~flush & ~hazard;
            bundle_d.pc            = id_pc;
            bundle_d.val_rn        = id_val_rn;
            bundle_d.val_rm        = id_val_rm;
            bundle_d.imm           = id_imm;
            bundle_d.shift_operand = id_shift_operand;
            bundle_d.signed_imm_24 = id_signed_imm_24;
            bundle_d.dest          = id_dest;
            bundle_d.src1          = id_src1;
            bundle_d.src2          = id_src2;
            bundle_d.exe_cmd       = bubble ? EXE_NOP : id_exe_cmd;
            bundle_d.wb_en         = id_wb_en    & ~bubble;
            bundle_d.mem_r_en      = id_mem_r_en & ~bubble;
            bundle_d.mem_w_en      = id_mem_w_en & ~bubble;
            bundle_d.b             = id_b        & ~bubble;
            bundle_d.s             = id_s        & ~bubble;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    // The S-instruction leaving EXE retires even when a flush squashes ID.
    assign status_en = ~mem_freeze & bundle_q.valid & bundle_q.s;

    status_reg #(
        .WIDTH (4)
    ) u_status_reg (
        .clk (clk),
        .rst (rst),
        .en  (status_en),
        .d   (alu_flags),
        .q   (status)
    );

    assign exe_valid         = bundle_q.valid;
    assign exe_pc            = bundle_q.pc;
    assign exe_val_rn        = bundle_q.val_rn;
    assign exe_val_rm        = bundle_q.val_rm;
    assign exe_imm           = bundle_q.imm;
    assign exe_shift_operand = bundle_q.shift_operand;
    assign exe_signed_imm_24 = bundle_q.signed_imm_24;
    assign exe_dest          = bundle_q.dest;
    assign exe_src1          = bundle_q.src1;
    assign exe_src2          = bundle_q.src2;
    assign exe_exe_cmd       = bundle_q.exe_cmd;
    assign exe_wb_en         = bundle_q.wb_en;
    assign exe_mem_r_en      = bundle_q.mem_r_en;
    assign exe_mem_w_en      = bundle_q.mem_w_en;
    assign exe_b             = bundle_q.b;
    assign exe_s             = bundle_q.s;

endmodule : id_exe_pipe_reg
`default_nettype wire
